// File: rtl/mic1_mem_ctrl_if.sv
// Memory-side bus of the MIC-1 memory controller: one outstanding word
// request at a time, completed by mem_ack with any number of wait cycles.
interface mic1_mem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mic1_mem_ctrl.sv
// MIC-1 memory controller. Takes the {wr, rd, fetch} bits of the current
// microinstruction, turns them into word requests on the memory bus and
// returns the results in MDR (rd) and MBR (fetch). A data operation issued
// together with a fetch runs first, and the fetch follows directly without
// passing through IDLE. busy stalls the microsequencer while work is pending.
module mic1_mem_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             mem_ops,
    input  logic [31:0]            MAR,
    input  logic [31:0]            MDR_in,
    input  logic [31:0]            PC,
    output logic [31:0]            MDR,
    output logic                   mdr_valid,
    output logic [7:0]             MBR,
    output logic                   mbr_valid,
    output logic                   busy,
    mic1_mem_ctrl_if.master        mem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_e;

    state_e      state_q,     state_d;
    logic        wr_q,        wr_d;
    logic        rd_q,        rd_d;
    logic        fetch_q,     fetch_d;
    logic [29:0] mar_q,       mar_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] mdr_q,       mdr_d;
    logic [7:0]  mbr_q,       mbr_d;
    logic        mdr_valid_q, mdr_valid_d;
    logic        mbr_valid_q, mbr_valid_d;

    logic [7:0]  fetch_byte;
    logic        req_o;
    logic        we_o;
    logic [29:0] addr_o;
    logic [31:0] wdata_o;

    // MAR is a word address; its top two bits have no meaning on this bus.
    logic unused_mar_hi;
    assign unused_mar_hi = ^MAR[31:30];

    // Big-endian byte lane chosen by the low two bits of the latched PC.
    always_comb begin
        fetch_byte = 8'h00;
        case (pc_q[1:0])
            2'b00:   fetch_byte = mem.mem_rdata[31:24];
            2'b01:   fetch_byte = mem.mem_rdata[23:16];
            2'b10:   fetch_byte = mem.mem_rdata[15:8];
            default: fetch_byte = mem.mem_rdata[7:0];
        endcase
    end

    // Next-state logic: accept new work only in IDLE, sequence DATA then FETCH.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        fetch_d     = fetch_q;
        mar_d       = mar_q;
        wdata_d     = wdata_q;
        pc_d        = pc_q;
        mdr_d       = mdr_q;
        mbr_d       = mbr_q;
        mdr_valid_d = 1'b0;
        mbr_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_ops != 3'b000) begin
                    wr_d    = mem_ops[2];
                    rd_d    = mem_ops[1] & ~mem_ops[2];
                    fetch_d = mem_ops[0];
                    mar_d   = MAR[29:0];
                    wdata_d = MDR_in;
                    pc_d    = PC;
                    if (mem_ops[2] | mem_ops[1]) begin
                        state_d = DATA;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            DATA: begin
                if (mem.mem_ack) begin
                    if (rd_q) begin
                        mdr_d       = mem.mem_rdata;
                        mdr_valid_d = 1'b1;
                    end
                    if (fetch_q) begin
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FETCH: begin
                if (mem.mem_ack) begin
                    mbr_d       = fetch_byte;
                    mbr_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched operands and result registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            fetch_q     <= 1'b0;
            mar_q       <= 30'd0;
            wdata_q     <= 32'd0;
            pc_q        <= 32'd0;
            mdr_q       <= 32'd0;
            mbr_q       <= 8'd0;
            mdr_valid_q <= 1'b0;
            mbr_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            fetch_q     <= fetch_d;
            mar_q       <= mar_d;
            wdata_q     <= wdata_d;
            pc_q        <= pc_d;
            mdr_q       <= mdr_d;
            mbr_q       <= mbr_d;
            mdr_valid_q <= mdr_valid_d;
            mbr_valid_q <= mbr_valid_d;
        end
    end

    // Bus drive decoded from state; everything idles at zero outside a request.
    always_comb begin
        req_o   = 1'b0;
        we_o    = 1'b0;
        addr_o  = 30'd0;
        wdata_o = 32'd0;
        case (state_q)
            DATA: begin
                req_o   = 1'b1;
                we_o    = wr_q;
                addr_o  = mar_q;
                wdata_o = wdata_q;
            end
            FETCH: begin
                req_o   = 1'b1;
                addr_o  = pc_q[31:2];
            end
            default: begin
                req_o   = 1'b0;
            end
        endcase
    end

    assign mem.mem_req   = req_o;
    assign mem.mem_we    = we_o;
    assign mem.mem_addr  = addr_o;
    assign mem.mem_wdata = wdata_o;

    assign busy      = (state_q != IDLE);
    assign MDR       = mdr_q;
    assign MBR       = mbr_q;
    assign mdr_valid = mdr_valid_q;
    assign mbr_valid = mbr_valid_q;

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
// Directed bench for mic1_mem_ctrl. Inputs change and outputs are sampled
// on the falling edge, so each step is exactly one rising edge of the DUT.
module tb_mic1_mem_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  mem_ops;
    logic [31:0] MAR;
    logic [31:0] MDR_in;
    logic [31:0] PC;
    logic [31:0] MDR;
    logic        mdr_valid;
    logic [7:0]  MBR;
    logic        mbr_valid;
    logic        busy;

    int tests_run;
    int tests_failed;

    mic1_mem_ctrl_if mem_bus ();

    mic1_mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .mem_ops   (mem_ops),
        .MAR       (MAR),
        .MDR_in    (MDR_in),
        .PC        (PC),
        .MDR       (MDR),
        .mdr_valid (mdr_valid),
        .MBR       (MBR),
        .mbr_valid (mbr_valid),
        .busy      (busy),
        .mem       (mem_bus.master)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every output folded together so reset can be checked in one compare.
    function automatic logic [106:0] all_outputs();
        return {MDR, MBR, mdr_valid, mbr_valid, busy, mem_bus.mem_req,
                mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata};
    endfunction

    task test_reset;
        rst = 1'b0;
        mem_ops = 3'b000;
        MAR = 32'd0;
        MDR_in = 32'd0;
        PC = 32'd0;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = 32'd0;
        #1;
        tests_run++;
        if (all_outputs() !== 107'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_immediate: got %h want 0", all_outputs());
        end
        @(negedge clk);
        tests_run++;
        if (all_outputs() !== 107'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_held: got %h want 0", all_outputs());
        end
        rst = 1'b1;
    endtask

    task test_read;
        MAR = 32'd5;
        mem_ops = 3'b010;
        @(negedge clk);
        mem_ops = 3'b000;
        tests_run++;
        if ({mem_bus.mem_req, mem_bus.mem_we, busy} !== 3'b101 || mem_bus.mem_addr !== 30'd5) begin
            tests_failed++;
            $display("[TB] FAIL read_request: got req/we/busy=%b addr=%h want 101 addr=5",
                     {mem_bus.mem_req, mem_bus.mem_we, busy}, mem_bus.mem_addr);
        end
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        tests_run++;
        if (MDR !== 32'hDEADBEEF || {mdr_valid, busy, mem_bus.mem_req} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL read_result: got MDR=%h valid/busy/req=%b want deadbeef 100",
                     MDR, {mdr_valid, busy, mem_bus.mem_req});
        end
        @(negedge clk);
        tests_run++;
        if (mdr_valid !== 1'b0 || MDR !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("[TB] FAIL read_pulse_end: got valid=%b MDR=%h want 0 deadbeef", mdr_valid, MDR);
        end
    endtask

    task test_fetch;
        PC = 32'h00000006;
        mem_ops = 3'b001;
        @(negedge clk);
        mem_ops = 3'b000;
        tests_run++;
        if ({mem_bus.mem_req, mem_bus.mem_we, busy} !== 3'b101 || mem_bus.mem_addr !== 30'd1) begin
            tests_failed++;
            $display("[TB] FAIL fetch_request: got req/we/busy=%b addr=%h want 101 addr=1",
                     {mem_bus.mem_req, mem_bus.mem_we, busy}, mem_bus.mem_addr);
        end
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'h11223344;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        tests_run++;
        if (MBR !== 8'h33 || {mbr_valid, mdr_valid, busy} !== 3'b100 || MDR !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("[TB] FAIL fetch_result: got MBR=%h mbrv/mdrv/busy=%b MDR=%h want 33 100 deadbeef",
                     MBR, {mbr_valid, mdr_valid, busy}, MDR);
        end
        @(negedge clk);
        tests_run++;
        if (mbr_valid !== 1'b0 || MBR !== 8'h33) begin
            tests_failed++;
            $display("[TB] FAIL fetch_pulse_end: got valid=%b MBR=%h want 0 33", mbr_valid, MBR);
        end
    endtask

    task test_combined;
        MAR = 32'd2;
        MDR_in = 32'hA5A5A5A5;
        PC = 32'd0;
        mem_ops = 3'b111;
        @(negedge clk);
        mem_ops = 3'b000;
        tests_run++;
        if ({mem_bus.mem_req, mem_bus.mem_we, busy} !== 3'b111 || mem_bus.mem_addr !== 30'd2
            || mem_bus.mem_wdata !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("[TB] FAIL combo_write: got req/we/busy=%b addr=%h wdata=%h want 111 2 a5a5a5a5",
                     {mem_bus.mem_req, mem_bus.mem_we, busy}, mem_bus.mem_addr, mem_bus.mem_wdata);
        end
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_bus.mem_rdata = 32'h7788AABB;
        tests_run++;
        if ({mem_bus.mem_req, mem_bus.mem_we, busy, mdr_valid} !== 4'b1010 || mem_bus.mem_addr !== 30'd0
            || MDR !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("[TB] FAIL combo_fetch_phase: got req/we/busy/mdrv=%b addr=%h MDR=%h want 1010 0 deadbeef",
                     {mem_bus.mem_req, mem_bus.mem_we, busy, mdr_valid}, mem_bus.mem_addr, MDR);
        end
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        tests_run++;
        if (MBR !== 8'h77 || {mbr_valid, mdr_valid, busy, mem_bus.mem_req} !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL combo_result: got MBR=%h mbrv/mdrv/busy/req=%b want 77 1000",
                     MBR, {mbr_valid, mdr_valid, busy, mem_bus.mem_req});
        end
    endtask

    task test_delayed_ack;
        int busy_cycles;
        busy_cycles = 0;
        MAR = 32'd9;
        mem_ops = 3'b010;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({mem_bus.mem_req, busy} !== 2'b11 || mem_bus.mem_addr !== 30'd9) begin
                tests_failed++;
                $display("[TB] FAIL delay_wait%0d: got req/busy=%b addr=%h want 11 9",
                         i, {mem_bus.mem_req, busy}, mem_bus.mem_addr);
            end
            if (busy === 1'b1) busy_cycles++;
            mem_ops = 3'b101;
            MAR = 32'd20 + i;
            PC = 32'h100 + i;
            if (i == 3) begin
                mem_ops = 3'b000;
                mem_bus.mem_ack = 1'b1;
                mem_bus.mem_rdata = 32'h12345678;
            end
            @(negedge clk);
        end
        mem_bus.mem_ack = 1'b0;
        tests_run++;
        if (MDR !== 32'h12345678 || {mdr_valid, busy} !== 2'b10 || busy_cycles != 4) begin
            tests_failed++;
            $display("[TB] FAIL delay_result: got MDR=%h valid/busy=%b busy_cycles=%0d want 12345678 10 4",
                     MDR, {mdr_valid, busy}, busy_cycles);
        end
        @(negedge clk);
        tests_run++;
        if ({mem_bus.mem_req, busy, mbr_valid} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL delay_ignored_ops: got req/busy/mbrv=%b want 000",
                     {mem_bus.mem_req, busy, mbr_valid});
        end
    endtask

    task test_back_to_back;
        MAR = 32'd7;
        MDR_in = 32'h55AA00FF;
        mem_ops = 3'b100;
        @(negedge clk);
        mem_ops = 3'b000;
        tests_run++;
        if ({mem_bus.mem_req, mem_bus.mem_we, busy} !== 3'b111 || mem_bus.mem_addr !== 30'd7
            || mem_bus.mem_wdata !== 32'h55AA00FF) begin
            tests_failed++;
            $display("[TB] FAIL b2b_write: got req/we/busy=%b addr=%h wdata=%h want 111 7 55aa00ff",
                     {mem_bus.mem_req, mem_bus.mem_we, busy}, mem_bus.mem_addr, mem_bus.mem_wdata);
        end
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        tests_run++;
        if (MDR !== 32'h12345678 || {mdr_valid, busy} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL b2b_write_done: got MDR=%h valid/busy=%b want 12345678 00",
                     MDR, {mdr_valid, busy});
        end
        MAR = 32'd8;
        mem_ops = 3'b010;
        @(negedge clk);
        mem_ops = 3'b000;
        tests_run++;
        if ({mem_bus.mem_req, mem_bus.mem_we} !== 2'b10 || mem_bus.mem_addr !== 30'd8) begin
            tests_failed++;
            $display("[TB] FAIL b2b_read_request: got req/we=%b addr=%h want 10 8",
                     {mem_bus.mem_req, mem_bus.mem_we}, mem_bus.mem_addr);
        end
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        tests_run++;
        if (MDR !== 32'h0BADF00D || mdr_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_read_result: got MDR=%h valid=%b want 0badf00d 1", MDR, mdr_valid);
        end
        PC = 32'h0000000B;
        mem_ops = 3'b001;
        @(negedge clk);
        mem_ops = 3'b000;
        tests_run++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 30'd2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_fetch_request: got req=%b addr=%h want 1 2",
                     mem_bus.mem_req, mem_bus.mem_addr);
        end
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'h11223344;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        tests_run++;
        if (MBR !== 8'h44 || mbr_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_fetch_result: got MBR=%h valid=%b want 44 1", MBR, mbr_valid);
        end
    endtask

    task test_reset_mid_fetch;
        PC = 32'h0000000D;
        mem_ops = 3'b001;
        @(negedge clk);
        mem_ops = 3'b000;
        tests_run++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 30'd3) begin
            tests_failed++;
            $display("[TB] FAIL midrst_request: got req=%b addr=%h want 1 3",
                     mem_bus.mem_req, mem_bus.mem_addr);
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (all_outputs() !== 107'd0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_immediate: got %h want 0", all_outputs());
        end
        @(negedge clk);
        rst = 1'b1;
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        tests_run++;
        if (MBR !== 8'h00 || {mbr_valid, busy, mem_bus.mem_req} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL midrst_late_ack: got MBR=%h valid/busy/req=%b want 00 000",
                     MBR, {mbr_valid, busy, mem_bus.mem_req});
        end
    endtask

    task test_idle;
        mem_ops = 3'b000;
        for (int i = 0; i < 10; i++) begin
            mem_bus.mem_ack = i[0];
            mem_bus.mem_rdata = 32'h5A5A5A5A;
            @(negedge clk);
            tests_run++;
            if ({mem_bus.mem_req, busy, mdr_valid, mbr_valid} !== 4'b0000 || MDR !== 32'd0) begin
                tests_failed++;
                $display("[TB] FAIL idle_cycle%0d: got req/busy/mdrv/mbrv=%b MDR=%h want 0000 0",
                         i, {mem_bus.mem_req, busy, mdr_valid, mbr_valid}, MDR);
            end
        end
        mem_bus.mem_ack = 1'b0;
    endtask

    // Scenario sequence; the first request follows reset release with no gap.
    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_read();
        test_fetch();
        test_combined();
        test_delayed_ack();
        test_back_to_back();
        test_reset_mid_fetch();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mic1_mem_ctrl.md
MIC1_MEM_CTRL -- requirements
Module: mic1_mem_ctrl

Interface
REQ-001 SHALL provide ports: clk  in  1  sole clock, rising-edge.
REQ-002 SHALL provide: rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL provide: mem_ops  in  3  {wr, rd, fetch} memory bits of the current MIR, sampled only when accepted.
REQ-004 SHALL provide: MAR  in  32  word address for rd/wr.
REQ-005 SHALL provide: MDR_in  in  32  write data for wr.
REQ-006 SHALL provide: PC  in  32  byte address for fetch.
REQ-007 SHALL provide: MDR  out  32  last word read.
REQ-008 SHALL provide: mdr_valid  out  1  one-cycle pulse when MDR updated by rd.
REQ-009 SHALL provide: MBR  out  8  last byte fetched; feeds controlpath MBR.
REQ-010 SHALL provide: mbr_valid  out  1  one-cycle pulse when MBR updated.
REQ-011 SHALL provide: busy  out  1  high while any accepted operation is outstanding (stalls microsequencing).
REQ-012 SHALL provide: mem_req  out  1  request to external word memory.
REQ-013 SHALL provide: mem_we  out  1  1 = write, 0 = read, valid with mem_req.
REQ-014 SHALL provide: mem_addr  out  30  word address.
REQ-015 SHALL provide: mem_wdata  out  32  write data.
REQ-016 SHALL provide: mem_rdata  in  32  read data, valid with mem_ack.
REQ-017 SHALL provide: mem_ack  in  1  completion of current mem_req, any latency >= 0 extra cycles.

Function
REQ-018 SHALL implement FSM states IDLE, DATA (rd/wr in progress), FETCH (fetch in progress).
REQ-019 SHALL accept mem_ops only in IDLE with mem_ops != 0; in non-IDLE states mem_ops is ignored.
REQ-020 On accept, SHALL latch MAR[29:0], MDR_in, PC and op bits into internal registers in the same edge.
REQ-021 wr and rd both set SHALL be treated as wr only; rd is dropped.
REQ-022 With data op plus fetch accepted together, SHALL perform DATA first, then FETCH, without returning to IDLE in between.
REQ-023 DATA: mem_req=1, mem_we=wr, mem_addr=latched MAR[29:0], mem_wdata=latched MDR_in, held stable until mem_ack sampled high.
REQ-024 FETCH: mem_req=1, mem_we=0, mem_addr=latched PC[31:2].
REQ-025 On mem_ack in DATA with rd: MDR <= mem_rdata, mdr_valid=1 next cycle for exactly one cycle; wr: MDR unchanged, no pulse.
REQ-026 On mem_ack in FETCH: MBR <= big-endian byte selected by PC[1:0] (00 -> rdata[31:24], 11 -> rdata[7:0]); mbr_valid one-cycle pulse.
REQ-027 Minimum latency: accept at edge k, mem_req high in cycle k+1, ack in k+1 -> MDR/MBR updated at edge k+2; each extra ack wait cycle adds one cycle.
REQ-028 busy SHALL be combinationally high whenever state != IDLE; low in IDLE; it SHALL drop in the cycle the result register is written.
REQ-029 mem_req SHALL deassert the cycle after ack unless the next phase (FETCH after DATA) begins, in which case it stays high with new address.
REQ-030 mem_ack while mem_req=0 SHALL be ignored.
REQ-031 MDR and MBR SHALL hold values indefinitely between updates.

Reset
REQ-032 rst=0 SHALL immediately force state IDLE, MDR=0, MBR=0, mdr_valid=0, mbr_valid=0, busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset mid-operation SHALL abandon the transaction; no late ack updates MDR/MBR after rst release.
REQ-034 First accept possible on the first rising edge with rst=1.

Verification
REQ-035 rd, MAR=5, mem_ack same cycle as mem_req, rdata=0xDEADBEEF -> mem_addr=5, MDR=0xDEADBEEF at edge k+2, mdr_valid one cycle.
REQ-036 fetch, PC=0x00000006, rdata=0x11223344 -> mem_addr=1, MBR=0x33, mbr_valid one cycle, MDR unchanged.
REQ-037 wr+rd+fetch, MAR=2, MDR_in=0xA5A5A5A5, PC=0 -> write to addr 2 (mem_we=1), then read addr 0, MBR=rdata[31:24], no mdr_valid.
REQ-038 rd with mem_ack delayed 3 cycles -> busy high 4 cycles, mem_addr stable, new mem_ops during busy ignored.
REQ-039 rst=0 asserted while in FETCH awaiting ack -> all outputs zero immediately; ack after release -> MBR stays 0.
REQ-040 mem_ops=0 for 10 cycles -> mem_req never asserted, busy=0.
